shared_data_memory: RTL

Parametrised, multi-port shared data memory for the multi-core CPU, replacing the fixed two-port data memory. NUM_PORTS core-side load/store ports share one byte-addressed, little-endian storage array through a round-robin arbiter with a request/ready handshake, so simultaneous accesses serialise deterministically instead of racing. Adds byte-enable writes, a registered read-data path with a valid strobe, and out-of-range error reporting. Sits between each core's MEM stage and the single backing array; cores stall while their `ready_o` is low.

---
 rtl/shared_data_memory_if.sv | 26 ++
 rtl/shared_data_memory.sv | 119 +++++++++++
 2 files changed

// File: rtl/shared_data_memory_if.sv
// Per-port load/store bus between the cores' MEM stages and the shared data memory.
// Port p occupies bit p of the scalar vectors and slice p of the packed buses.
interface shared_data_memory_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32
);
  logic [NUM_PORTS-1:0]        req_i;
  logic [NUM_PORTS-1:0]        we_i;
  logic [NUM_PORTS*ADDR_W-1:0] addr_i;
  logic [NUM_PORTS*32-1:0]     wdata_i;
  logic [NUM_PORTS*4-1:0]      be_i;
  logic [NUM_PORTS-1:0]        ready_o;
  logic [NUM_PORTS-1:0]        rvalid_o;
  logic [NUM_PORTS*32-1:0]     rdata_o;
  logic [NUM_PORTS-1:0]        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  ready_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output ready_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/shared_data_memory.sv
// Multi-port shared data memory: round-robin arbitrated, byte-enabled, little-endian
// word storage with registered per-port read data, valid strobe and range error.
module shared_data_memory #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  shared_data_memory_if.slave  bus
);
  localparam int unsigned WORDS = DEPTH_BYTES / 4;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_BYTES);

  // Storage is zero at power-up and deliberately left untouched by rst_i.
  logic [31:0] mem_q [WORDS] = '{default: '0};

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]   req_rot;
  logic [NUM_PORTS-1:0]   gnt;
  logic                   gnt_any;
  int unsigned            gnt_off;
  int unsigned            gnt_k;

  logic [ADDR_W-1:0]      sel_addr;
  logic [31:0]            sel_wdata;
  logic [3:0]             sel_be;
  logic                   sel_we;
  logic                   sel_in_range;
  logic [IDX_W-1:0]       sel_word;
  logic [31:0]            rd_word;

  logic [NUM_PORTS-1:0]   rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0]   err_q, err_d;
  logic [NUM_PORTS*32-1:0] rdata_q, rdata_d;

  // Rotate requests so that bit 0 is the port at ptr; the first set bit wins.
  always_comb begin
    req_rot = NUM_PORTS'({bus.req_i, bus.req_i} >> ptr_q);
    gnt_any = 1'b0;
    gnt_off = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_any && req_rot[i]) begin
        gnt_any = 1'b1;
        gnt_off = i;
      end
    end
    gnt_any = gnt_any & ~rst_i;
    gnt_k   = (32'(ptr_q) + gnt_off) % NUM_PORTS;
    gnt     = '0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      gnt[j] = gnt_any && (j == gnt_k);
    end
    ptr_d = gnt_any ? PTR_W'((gnt_k + 1) % NUM_PORTS) : ptr_q;
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_we    = 1'b0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (gnt[j]) begin
        sel_addr  = bus.addr_i[j*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata_i[j*32 +: 32];
        sel_be    = bus.be_i[j*4 +: 4];
        sel_we    = bus.we_i[j];
      end
    end
    sel_in_range = (sel_addr < DEPTH_A);
    sel_word     = sel_addr[IDX_W+1:2];
    rd_word      = mem_q[sel_word];
  end

  always_comb begin
    rvalid_d = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (gnt[j]) begin
        err_d[j] = ~sel_in_range;
        if (!sel_we) begin
          rvalid_d[j]          = 1'b1;
          rdata_d[j*32 +: 32]  = sel_in_range ? rd_word : '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt_any && sel_we && sel_in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_be[b]) mem_q[sel_word][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  // Gating by rst_i drops a strobe that would otherwise land in the reset cycle.
  assign bus.ready_o  = gnt;
  assign bus.rvalid_o = rst_i ? '0 : rvalid_q;
  assign bus.err_o    = rst_i ? '0 : err_q;
  assign bus.rdata_o  = rst_i ? '0 : rdata_q;
endmodule
